// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 device-side transmitter: FSM states,
// frame geometry, the break prefix byte and the odd-parity helper.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HIGH,
        LOW,
        GAP
    } ps2_state_e;

    localparam int         FRAME_BITS = 11;
    localparam logic [7:0] BREAK_CODE = 8'hF0;

    // Parity bit that makes data plus parity carry an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Small synchronous FIFO with a registered read port; rd_data_o becomes
// valid on the cycle after a pop.
module ps2_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             do_push, do_pop;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;
    assign rd_data_o = rd_data_q;

    // Storage carries no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
        if (do_pop) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard-side transmitter: queued scancodes are sent as 11-bit frames
// followed by an idle gap. Define PS2_TX_BREAK_EN to prefix released keys with 0xF0.
module ps2_kbd_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 50,
    parameter int GAP_HALVES = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
`ifdef PS2_TX_BREAK_EN
    input  logic       in_release,
`endif
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy
);

    localparam int GAP_CYC = GAP_HALVES * CLK_DIV;
    localparam int CNT_W   = $clog2(CLK_DIV + GAP_CYC + 1);
`ifdef PS2_TX_BREAK_EN
    localparam int ENTRY_W = 9;
`else
    localparam int ENTRY_W = 8;
`endif

    logic [ENTRY_W-1:0]    wr_entry, rd_entry;
    logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
    ps2_state_e            state_q, state_d, after_gap;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            bit_q, bit_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  ps2_clk_q, ps2_clk_d, ps2_data_q, ps2_data_d;
    logic [7:0]            tx_byte;
`ifdef PS2_TX_BREAK_EN
    logic                  pend_q, pend_d;
    logic [7:0]            hold_q, hold_d;

    assign wr_entry = {in_release, in_data};
`else
    assign wr_entry = in_data;
`endif

    assign fifo_push = in_valid && !fifo_full;
    assign in_ready  = !fifo_full;
    assign busy      = (state_q != IDLE) || !fifo_empty;
    assign ps2_clk   = ps2_clk_q;
    assign ps2_data  = ps2_data_q;

    ps2_tx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_i    (fifo_push),
        .wr_data_i (wr_entry),
        .pop_i     (fifo_pop),
        .rd_data_o (rd_entry),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        fifo_pop  = 1'b0;
        tx_byte   = rd_entry[7:0];
        after_gap = IDLE;
`ifdef PS2_TX_BREAK_EN
        pend_d = pend_q;
        hold_d = hold_q;
        // A pending data byte follows its 0xF0 prefix without touching the queue.
        if (pend_q) begin
            after_gap = LOAD;
        end
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
`ifdef PS2_TX_BREAK_EN
                if (pend_q) begin
                    tx_byte = hold_q;
                    pend_d  = 1'b0;
                end else if (rd_entry[8]) begin
                    tx_byte = BREAK_CODE;
                    hold_d  = rd_entry[7:0];
                    pend_d  = 1'b1;
                end
`endif
                frame_d = {1'b1, odd_parity(tx_byte), tx_byte, 1'b0};
                bit_d   = '0;
                cnt_d   = '0;
                state_d = HIGH;
            end
            HIGH: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d   = '0;
                    state_d = LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOW: begin
                if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (bit_q == 4'(FRAME_BITS - 1)) begin
                        state_d = (GAP_CYC == 0) ? after_gap : GAP;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        state_d = HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = after_gap;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line levels follow the next state so the pins are registered yet aligned.
        ps2_clk_d  = (state_d != LOW);
        ps2_data_d = (state_d == HIGH || state_d == LOW) ? frame_d[bit_d] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            frame_q    <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
`ifdef PS2_TX_BREAK_EN
            pend_q     <= 1'b0;
            hold_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            frame_q    <= frame_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
`ifdef PS2_TX_BREAK_EN
            pend_q     <= pend_d;
            hold_q     <= hold_d;
`endif
        end
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: a line-level PS/2 receiver decodes frames
// and compares them with a queue of bytes expected from the pushes.
module tb_ps2_kbd_tx;

    localparam int CD = 4;
    localparam int GH = 4;
    localparam int FD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_release = 1'b0;
    logic       in_ready, ps2_clk, ps2_data, busy;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    ps2_kbd_tx #(
        .CLK_DIV    (CD),
        .GAP_HALVES (GH),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
`ifdef PS2_TX_BREAK_EN
        .in_release (in_release),
`endif
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .busy       (busy)
    );

    // Receiver model: samples the lines just after each falling clk edge.
    logic        prev_clk = 1'b1;
    logic        low_data = 1'b1;
    logic [10:0] shreg = '0;
    int          nbits = 0;
    int          edges = 0;
    int          low_len = 0;
    int          low_viol = 0;
    int          data_viol = 0;
    logic [10:0] frames[$];
    logic [7:0]  exp_q[$];

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                nbits    = 0;
                prev_clk = 1'b1;
                low_len  = 0;
            end else begin
                if (prev_clk && !ps2_clk) begin
                    edges++;
                    shreg[nbits] = ps2_data;
                    nbits++;
                    low_len  = 1;
                    low_data = ps2_data;
                    if (nbits == 11) begin
                        frames.push_back(shreg);
                        nbits = 0;
                    end
                end else if (!ps2_clk) begin
                    low_len++;
                    if (ps2_data !== low_data) data_viol++;
                end else if (!prev_clk && ps2_clk) begin
                    if (low_len != CD) low_viol++;
                end
                prev_clk = ps2_clk;
            end
        end
    end

    // Expected frame from the byte: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2) == 0;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic push(input logic [7:0] d, input logic rel);
        int t;
        in_valid   = 1'b1;
        in_data    = d;
        in_release = rel;
        t = 0;
        while (!in_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        in_valid   = 1'b0;
        in_release = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, output logic ok);
        int n;
        n = 0;
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        ok = !busy;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ps2_clk !== 1'b1) $display("FAIL reset_ps2_clk: got %b want 1", ps2_clk);
        else passes++;
        checks++;
        if (ps2_data !== 1'b1) $display("FAIL reset_ps2_data: got %b want 1", ps2_data);
        else passes++;
        checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else passes++;
        reset = 1'b0;
        @(negedge clk);
        $display("reset done: ps2_clk=%b ps2_data=%b in_ready=%b busy=%b", ps2_clk, ps2_data, in_ready, busy);
    endtask

    task automatic test_scancode_1c();
        int         e0;
        logic       ok;
        logic [10:0] f;
        frames.delete();
        e0 = edges;
        push(8'h1C, 1'b0);
        wait_idle(1000, ok);
        checks++;
        if (!ok) $display("FAIL 1c_idle: busy still %b after timeout", busy);
        else passes++;
        checks++;
        if (edges - e0 != 11) $display("FAIL 1c_edges: got %0d want 11", edges - e0);
        else passes++;
        checks++;
        if (frames.size() != 1) begin
            $display("FAIL 1c_frames: got %0d frames want 1", frames.size());
        end else begin
            f = frames.pop_front();
            $display("frame 1c: bits=%b byte=%02h", f, f[8:1]);
            if (f !== 11'b100_0011_1000) $display("FAIL 1c_bits: got %b want 10000111000", f);
            else passes++;
            checks++;
            if (f[8:1] !== 8'h1C || ($countones(f[9:1]) % 2) != 1)
                $display("FAIL 1c_decode: got byte %02h parity_ok=%0d want 1c", f[8:1], $countones(f[9:1]) % 2);
            else passes++;
        end
    endtask

    task automatic test_parity();
        logic        ok;
        logic [10:0] f;
        frames.delete();
        push(8'h00, 1'b0);
        push(8'h01, 1'b0);
        wait_idle(2000, ok);
        checks++;
        if (!ok || frames.size() != 2) $display("FAIL parity_frames: got %0d frames want 2", frames.size());
        else passes++;
        if (frames.size() == 2) begin
            f = frames.pop_front();
            $display("frame parity: bits=%b byte=%02h", f, f[8:1]);
            checks++;
            if (f[9] !== 1'b1 || f !== exp_frame(8'h00)) $display("FAIL parity_00: got %b want %b", f, exp_frame(8'h00));
            else passes++;
            f = frames.pop_front();
            $display("frame parity: bits=%b byte=%02h", f, f[8:1]);
            checks++;
            if (f[9] !== 1'b0 || f !== exp_frame(8'h01)) $display("FAIL parity_01: got %b want %b", f, exp_frame(8'h01));
            else passes++;
        end
    endtask

    task automatic test_timing();
        int n, lv0, dv0, want;
        frames.delete();
        lv0  = low_viol;
        dv0  = data_viol;
        want = 1 + 22 * CD + GH * CD;
        push(8'hA5, 1'b0);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        // One sample is the idle cycle where the queue is non-empty before LOAD.
        $display("timing: load_to_idle=%0d cycles", n - 1);
        checks++;
        if (n - 1 != want) $display("FAIL timing_frame: got %0d cycles want %0d", n - 1, want);
        else passes++;
        checks++;
        if (low_viol != lv0) $display("FAIL timing_low_pulse: got %0d bad pulses want 0", low_viol - lv0);
        else passes++;
        checks++;
        if (data_viol != dv0) $display("FAIL timing_data_stable: got %0d changes while low want 0", data_viol - dv0);
        else passes++;
        checks++;
        if (frames.size() != 1 || frames[0] !== exp_frame(8'hA5))
            $display("FAIL timing_byte: got %0d frames want 1 of %b", frames.size(), exp_frame(8'hA5));
        else passes++;
        frames.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  v[6];
        int          idx, first_full, cyc;
        logic        ok;
        logic [10:0] f;
        logic [7:0]  e;
        v = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35};
        frames.delete();
        exp_q.delete();
        idx = 0;
        first_full = -1;
        cyc = 0;
        in_valid = 1'b1;
        while (idx < 6 && cyc < 5000) begin
            in_data = v[idx];
            if (in_ready) begin
                exp_q.push_back(v[idx]);
                idx++;
            end else if (first_full < 0) begin
                first_full = idx;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (first_full != 5) $display("FAIL b2b_ready_drop: accepts before full %0d want 5", first_full);
        else passes++;
        wait_idle(5000, ok);
        checks++;
        if (!ok || frames.size() != 6) $display("FAIL b2b_count: got %0d frames want 6", frames.size());
        else passes++;
        while (frames.size() > 0 && exp_q.size() > 0) begin
            f = frames.pop_front();
            e = exp_q.pop_front();
            $display("frame b2b: byte=%02h expect=%02h", f[8:1], e);
            checks++;
            if (f !== exp_frame(e)) $display("FAIL b2b_frame: got %b want %b", f, exp_frame(e));
            else passes++;
        end
    endtask

    task automatic test_random();
        logic [7:0]  b;
        logic        ok;
        logic [10:0] f;
        logic [7:0]  e;
        frames.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            push(b, 1'b0);
            repeat ($urandom_range(0, 120)) @(negedge clk);
        end
        wait_idle(8000, ok);
        checks++;
        if (!ok || frames.size() != 8) $display("FAIL rand_count: got %0d frames want 8", frames.size());
        else passes++;
        while (frames.size() > 0 && exp_q.size() > 0) begin
            f = frames.pop_front();
            e = exp_q.pop_front();
            $display("frame rand: byte=%02h expect=%02h", f[8:1], e);
            checks++;
            if (f !== exp_frame(e)) $display("FAIL rand_frame: got %b want %b", f, exp_frame(e));
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        int e0, e1, t;
        frames.delete();
        e0 = edges;
        push(8'h6B, 1'b0);
        push(8'h74, 1'b0);
        t = 0;
        while (edges - e0 < 6 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (edges - e0 < 6) $display("FAIL midreset_reach_bit5: got %0d edges want 6", edges - e0);
        else passes++;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        checks++;
        if (ps2_clk !== 1'b1 || ps2_data !== 1'b1 || busy !== 1'b0)
            $display("FAIL midreset_lines: got clk=%b data=%b busy=%b want 1 1 0", ps2_clk, ps2_data, busy);
        else passes++;
        reset    = 1'b0;
        in_valid = 1'b0;
        e1 = edges;
        repeat (400) @(negedge clk);
        $display("midreset: edges after reset=%0d busy=%b", edges - e1, busy);
        checks++;
        if (edges != e1 || busy !== 1'b0 || frames.size() != 0)
            $display("FAIL midreset_quiet: got %0d edges busy=%b frames=%0d want 0 0 0", edges - e1, busy, frames.size());
        else passes++;
    endtask

`ifdef PS2_TX_BREAK_EN
    task automatic test_break();
        int          e0;
        logic        ok;
        logic [10:0] f;
        frames.delete();
        e0 = edges;
        push(8'h1C, 1'b1);
        wait_idle(2000, ok);
        checks++;
        if (!ok || edges - e0 != 22 || frames.size() != 2)
            $display("FAIL break_edges: got %0d edges %0d frames want 22 2", edges - e0, frames.size());
        else passes++;
        if (frames.size() == 2) begin
            f = frames.pop_front();
            checks++;
            if (f !== exp_frame(8'hF0)) $display("FAIL break_prefix: got %b want %b", f, exp_frame(8'hF0));
            else passes++;
            f = frames.pop_front();
            checks++;
            if (f !== exp_frame(8'h1C)) $display("FAIL break_data: got %b want %b", f, exp_frame(8'h1C));
            else passes++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scancode_1c();
        test_parity();
        test_timing();
        test_back_to_back();
        test_random();
`ifdef PS2_TX_BREAK_EN
        test_break();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ps2_kbd_tx.md
PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50, meaning clk cycles per PS/2 half-period (legal range 2..1023).
REQ-002 SHALL have parameter GAP_HALVES, default 4, meaning idle half-periods inserted after each frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of queued entries (a power of 2).
REQ-004 SHALL have port clk, input, 1 bit: system clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port in_data, input, 8 bits: scancode byte to transmit.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data is offered.
REQ-008 SHALL have port in_ready, output, 1 bit: the queue can accept an entry.
REQ-009 SHALL have port in_release, input, 1 bit: the byte is a key release; present only with PS2_TX_BREAK_EN.
REQ-010 SHALL have port ps2_clk, output, 1 bit: PS/2 clock driven device-side; idles at 1.
REQ-011 SHALL have port ps2_data, output, 1 bit: PS/2 data; idles at 1.
REQ-012 SHALL have port busy, output, 1 bit: 1 whenever the FSM is outside IDLE or the queue is non-empty.

Function
REQ-013 SHALL accept an entry on a clk edge where in_valid and in_ready are both 1.
REQ-014 SHALL drive in_ready = !full; while full, in_valid is ignored and no data is lost or overwritten.
REQ-015 SHALL use a first-in first-out queue of FIFO_DEPTH entries; push and pop in the same cycle are both honoured.
REQ-016 SHALL use FSM states IDLE, LOAD, HIGH, LOW and GAP.
REQ-017 IDLE -> LOAD when the queue is non-empty; the pop occurs on that edge.
REQ-018 LOAD SHALL last 1 cycle and build the 11-bit frame, LSB first: start 0, data[0..7], parity, stop 1; then go to HIGH with bit index 0.
REQ-019 The parity bit SHALL equal ~^data, so data plus parity has odd weight.
REQ-020 HIGH SHALL last CLK_DIV cycles with ps2_clk=1 and ps2_data=frame[bit index]; then go to LOW.
REQ-021 LOW SHALL last CLK_DIV cycles with ps2_clk=0 and ps2_data held; then go to HIGH with index+1, or to GAP after index 10.
REQ-022 ps2_data SHALL change only in the first cycle of HIGH, never while ps2_clk=0.
REQ-023 GAP SHALL last GAP_HALVES*CLK_DIV cycles with ps2_clk=1 and ps2_data=1; then go to IDLE.
REQ-024 One frame SHALL take exactly 1 + 22*CLK_DIV + GAP_HALVES*CLK_DIV cycles, measured from LOAD through the end of GAP.
REQ-025 A queued entry SHALL produce exactly 11 ps2_clk falling edges per byte sent.
REQ-026 ps2_clk and ps2_data SHALL be registered outputs with no glitches.

Reset
REQ-027 On reset the FSM SHALL be in IDLE, the queue empty and counters 0, with ps2_clk=1, ps2_data=1, in_ready=1 and busy=0 on the following cycle.
REQ-028 Reset mid-frame SHALL abort the frame and drop all queued entries; an in_valid asserted during reset SHALL NOT be accepted.

Configuration
REQ-029 Macro PS2_TX_BREAK_EN defined: in_release is present and stored per entry (9-bit entries); popping an entry with release=1 SHALL send 0xF0 as a full frame plus GAP, then the data byte, with no other entry interleaved between them.
REQ-030 Macro PS2_TX_BREAK_EN undefined: in_release is absent, entries are 8 bits, and each entry sends exactly one frame.

Structure
REQ-031 SHALL take from shared package ps2_pkg: the FSM state enum, FRAME_BITS=11, BREAK_CODE=8'hF0 and the parity helper function.
REQ-032 SHALL instantiate a single sub-module ps2_tx_fifo (parameterised width and depth; outputs full/empty); all other logic stays in ps2_kbd_tx.

Verification
REQ-033 CLK_DIV=4, push 0x1C -> ps2_data across the 11 falling edges reads 0,0,0,1,1,1,0,0,0,0,1 and a connected PS/2 receiver reports 0x1C.
REQ-034 Push 0x00 -> parity bit 1; push 0x01 -> parity bit 0; a receiver parity check passes on both.
REQ-035 Hold in_valid for 6 back-to-back pushes (0x15,0x1D,0x24,0x2D,0x2C,0x35), FIFO_DEPTH=4 -> in_ready drops after 5 accepts (one popped at LOAD); frames arrive in push order with none lost.
REQ-036 Assert reset during bit 5 of a frame -> next cycle ps2_clk=1, ps2_data=1, busy=0; no further falling edges occur.
REQ-037 With PS2_TX_BREAK_EN, push 0x1C with in_release=1 -> 22 falling edges decoding to 0xF0 then 0x1C.
REQ-038 Timing check, CLK_DIV=4 and GAP_HALVES=4 -> 105 cycles from LOAD to IDLE; each ps2_clk low pulse is exactly 4 cycles.
